lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store unit between the ALU result (effective address) and an external handshaked data memory.
- Takes LOAD/STORE requests encoded with the shared load_store funct3 codes (LB_SB=000, LH_SH=001, LW_SW=010, LBU=100, LHU=101).
- Drives a req/gnt/rvalid word-aligned memory port with byte enables and returns sign- or zero-extended load data.
- Stalls the core until each access completes.

Parameters:
- ADDR_W, 32, address width of the core and memory address buses.
- TIMEOUT, 64, cycles to wait for mem_gnt or mem_rvalid before aborting. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ld_en  in  1  load request, held by the core while stall=1.
- st_en  in  1  store request, held by the core while stall=1.
- funct3  in  3  load_store encoding.
- addr  in  ADDR_W  effective byte address.
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load result; valid while done=1.
- stall  out  1  freeze PC/pipeline.
- done  out  1  one-cycle completion pulse.
- lsu_err  out  1  one-cycle pulse, coincident with done, on misalign, illegal funct3 or abort.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write.
- mem_addr  out  ADDR_W  word-aligned address, addr[1:0] forced to 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (async, rst=1): state=IDLE; rdata, done, lsu_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata all 0.
- stall = (state==IDLE & (ld_en|st_en)) | state==REQ | state==WAIT. It is combinational; stall=0 in DONE.

IDLE:
- With (ld_en|st_en), register addr, funct3, wdata and op.
- Check legality:
  - Both ld_en and st_en set -> illegal.
  - Load funct3 not in {000,001,010,100,101} -> illegal.
  - Store funct3 not in {000,001,010} -> illegal.
  - Halfword with addr[0]=1, or word with addr[1:0]!=00 -> misaligned.
- Illegal or misaligned -> DONE with lsu_err=1, rdata=0, no memory access.
- Otherwise -> REQ.

REQ:
- mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata stable until mem_gnt.
- On mem_gnt: store -> DONE; load -> WAIT. mem_req drops the next cycle.

WAIT:
- On mem_rvalid, capture the extended load data into rdata -> DONE.
- mem_rvalid is ignored in IDLE, REQ and DONE. The memory must not return rvalid in the gnt cycle.

DONE:
- done=1 for exactly one cycle, then -> IDLE unconditionally.
- The core advances on this edge, so the same request is never re-accepted.

Byte enables and store data:
- SB: mem_be = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
- SH: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
- SW: mem_be = 1111; mem_wdata = wdata.
- Loads: mem_be reflects the access size; mem_we=0.

Load extraction:
- Select the byte lane addr[1:0] or halfword lane addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Timing:
- Minimum latency: store 3 cycles and load 4 cycles from request to done, with gnt in the first REQ cycle and rvalid in the first WAIT cycle.

Other rules:
- rdata holds its last value outside DONE.
- Reset asserted mid-operation aborts the access immediately, with no done pulse. A late mem_rvalid after reset is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entering REQ or WAIT and increments each cycle spent in them.
  - Reaching TIMEOUT -> DONE with lsu_err=1, rdata=0, mem_req dropped.
  - Counter resets to 0.
- Undefined: no counter; REQ and WAIT wait indefinitely.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, gnt on the first REQ cycle -> mem_addr=0x100, mem_be=1111, mem_we=1, done at cycle 3, stall high for cycles 1-2.
- SB addr=0x103 wdata=0x000000A5 -> mem_addr=0x100, mem_be=1000, mem_wdata=0xA5A5A5A5.
- LB addr=0x202, mem_rdata=0x12803456 -> rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080. LH addr=0x202 -> 0x00001280.
- LW addr=0x101 -> no mem_req, done and lsu_err high on cycle 2, rdata=0. Same result for funct3=011 load, and for ld_en&st_en both set.
- LW with gnt delayed 5 cycles and rvalid delayed 3 more -> stall held throughout, mem_req held 6 cycles, done exactly one cycle.
- rst pulsed while in WAIT, then mem_rvalid=1 -> outputs 0, state IDLE, no done. With LSU_TIMEOUT_EN and TIMEOUT=4, gnt never asserted -> lsu_err with done after 4 REQ cycles.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_mem_ctrl_if : req/gnt/rvalid data-memory port bundle          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_mem_ctrl : load/store unit driving a handshaked data memory   |
// | Optional REQ/WAIT abort counter: define LSU_TIMEOUT_EN. Rev 1.0   |
// +------------------------------------------------------------------+
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ld_en,
  input  logic              i_st_en,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_lsu_err,
  lsu_mem_ctrl_if.master    io_mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic              r_store;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic              w_req;
  logic              w_ld_ok;
  logic              w_st_ok;
  logic              w_misalign;
  logic              w_bad;
  logic              w_tmo_hit;
  logic              w_abort;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_lane;
  logic              w_in_req;

  assign w_req      = i_ld_en | i_st_en;
  assign w_ld_ok    = i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_st_ok    = i_funct3 inside {3'b000, 3'b001, 3'b010};
  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  assign w_bad      = (i_ld_en & i_st_en) | (i_ld_en & ~w_ld_ok) |
                      (i_st_en & ~w_st_ok) | w_misalign;

  assign w_abort = w_tmo_hit &&
                   (((r_state == S_REQ)  && !io_mem.mem_gnt) ||
                    ((r_state == S_WAIT) && !io_mem.mem_rvalid));

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT + 1) < 8)  ? 8  :
                         ($clog2(TIMEOUT + 1) > 16) ? 16 : $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Any state change clears the count, so entering REQ or WAIT starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_next != r_state) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_tmo_hit = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_tmo_hit        = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = w_bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (io_mem.mem_gnt) begin
          w_next = r_store ? S_DONE : S_WAIT;
        end else if (w_abort) begin
          w_next = S_DONE;
        end
      end
      S_WAIT: begin
        if (io_mem.mem_rvalid || w_abort) begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_byte = io_mem.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? io_mem.mem_rdata[31:16] : io_mem.mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'h000000, w_byte};
      3'b101:  w_ext = {16'h0000, w_half};
      default: w_ext = io_mem.mem_rdata;
    endcase
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b00: begin
        w_be         = 4'b0001 << r_addr[1:0];
        w_wdata_lane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be         = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_lane = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be         = 4'b1111;
        w_wdata_lane = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_funct3 <= 3'b000;
      r_wdata  <= 32'h0;
      r_store  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr   <= i_addr;
            r_funct3 <= i_funct3;
            r_wdata  <= i_wdata;
            r_store  <= i_st_en;
            r_err    <= w_bad;
            if (w_bad) begin
              r_rdata <= 32'h0;
            end
          end
        end
        S_REQ, S_WAIT: begin
          if ((r_state == S_WAIT) && io_mem.mem_rvalid) begin
            r_rdata <= w_ext;
          end else if (w_abort) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory-side outputs are gated by REQ so they read zero outside a live request.
  assign w_in_req         = (r_state == S_REQ);
  assign io_mem.mem_req   = w_in_req;
  assign io_mem.mem_we    = w_in_req & r_store;
  assign io_mem.mem_addr  = w_in_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign io_mem.mem_be    = w_in_req ? w_be : 4'b0000;
  assign io_mem.mem_wdata = (w_in_req && r_store) ? w_wdata_lane : 32'h0;

  assign o_stall   = ((r_state == S_IDLE) && w_req) || (r_state == S_REQ) || (r_state == S_WAIT);
  assign o_done    = (r_state == S_DONE);
  assign o_lsu_err = (r_state == S_DONE) && r_err;
  assign o_rdata   = r_rdata;

endmodule
`default_nettype wire
